// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/handshake bundle for the bit-serial adder.
//   master : start, a, b, cin driven; busy, done, sum, cout (ovf) observed
//   slave  : the adder itself
// When SERIAL_ADDER_OVF_EN is defined the bundle also carries ovf
// (signed overflow of the last result).
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder cell plus a
// registered carry, LSB first.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_adder_if.slave
//           start/a/b/cin in (sampled only in IDLE),
//           busy (WIDTH cycles), done (1-cycle pulse), sum/cout held
//           until the next completion.
// Optional: SERIAL_ADDER_OVF_EN adds bus.ovf, the two's-complement
// overflow of the result, registered and held like sum/cout.
// Throughput is one result per WIDTH+2 cycles (IDLE, WIDTH x RUN, DONE).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // The single full-adder cell: current LSBs plus the carry register.
  logic fa_s, fa_c;
  assign fa_s = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
  assign fa_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    ps_d    = ps_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        c_d    = fa_c;
        ps_d   = {fa_s, ps_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        // Last bit: publish result on this edge so sum/cout never show
        // a partial value.
        if (cnt_q == LAST) begin
          sum_d   = {fa_s, ps_q[WIDTH-1:1]};
          cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q is the carry into the MSB, fa_c the carry out of it.
          ovf_d   = c_q ^ fa_c;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      ps_q    <= ps_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around one full-adder cell plus a registered carry.
- Adds one bit per clock, LSB first, and replaces a WIDTH-wide ripple array where area matters more than latency.
- Sits directly downstream of the combinational full adder: it consumes that cell's sum/cout each cycle and feeds the carry back into cin.
- Upstream logic hands it operands with a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request an addition; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result; held until next completion
- cout  output  1  final carry-out; held until next completion

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, any time, including mid-operation):
  - state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift regs/counter/carry=0.
  - An in-flight operation is discarded with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: load a, b into operand shift regs, load carry reg with cin, clear bit counter, go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - busy=1.
  - Each edge: s = a_sr[0]^b_sr[0]^c; c <= majority(a_sr[0], b_sr[0], c).
  - Shift both operand regs right by 1, shift s into the MSB of the partial-sum reg, counter++.
  - On the edge that processes bit WIDTH-1: copy the partial sum to sum, copy the new carry to cout, go to DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle, then unconditionally return to IDLE.
- Latency:
  - start sampled at edge E0.
  - busy high for exactly WIDTH cycles.
  - done high in the cycle after edge E(WIDTH); sum/cout update on that same edge.
  - Throughput is one result per WIDTH+2 cycles.
- start while busy=1 or done=1: ignored, no effect on operands or result. Holding start high continuously produces back-to-back operations separated by the IDLE cycle.
- a, b, cin may change freely after acceptance; only the values at the accepting edge matter.
- sum/cout never glitch during RUN: they hold the previous result until the completing edge.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1); no saturation.
- Counter width: clog2(WIDTH)+1 bits; wrap-around never reached because RUN exits at WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit): two's-complement signed overflow, computed as the carry into the MSB XOR the carry out of the MSB.
  - ovf is registered alongside sum/cout, resets to 0, and holds until the next completion.
- Undefined:
  - Port ovf is absent, with no extra logic.
  - All other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x0F, b=0x01, cin=0, one-cycle start -> busy high 8 cycles, done pulse 9 cycles after start edge, sum=0x10, cout=0.
- a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; then a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. The first result must be held until the second done.
- Start accepted with a=0x12, b=0x34; pulse start again with a=0xAA, b=0x55 mid-RUN -> ignored, single done, sum=0x46.
- Start a=0x80, b=0x80; drop rst_n for 1 cycle after 4 RUN cycles -> busy/done/sum/cout immediately 0, no done pulse, FSM in IDLE. A new start with a=0x01, b=0x02 then yields sum=0x03.
- start held high for 30 cycles with fixed a=0x05, b=0x03 -> done every 10 cycles, sum=0x08 each time.
- With SERIAL_ADDER_OVF_EN:
  - a=0x7F, b=0x01 -> sum=0x80, ovf=1, cout=0.
  - a=0xFF, b=0x01 -> ovf=0, cout=1.
